// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - raster timing generator: pixel-enable divider, x/y counters, sync decode, delayed sync copies
module vga_sync_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 4,
    parameter int PIPE_DLY  = 1
) (
    input  logic       clk,
    input  logic       reset_game,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_tick,
    output logic       hsync_d,
    output logic       vsync_d,
    output logic       video_on_d
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [2:0] DIV_MAX  = 3'(CLK_DIV - 1);
    localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [2:0] div_q, div_d;
    logic [9:0] h_q, h_d, v_q, v_d;
    logic       hs_q, hs_d, vs_q, vs_d, von_q, von_d;
    logic       tick_raw, h_end, v_end;

    // Decode is taken from the next-state counters so sync/video registers line up with pixel_x/pixel_y.
    always_comb begin
        tick_raw = (div_q == DIV_MAX);
        h_end    = (h_q == H_MAX);
        v_end    = (v_q == V_MAX);
        div_d    = tick_raw ? 3'd0 : div_q + 3'd1;
        h_d      = h_q;
        v_d      = v_q;
        if (tick_raw) begin
            h_d = h_end ? 10'd0 : h_q + 10'd1;
            if (h_end) begin
                v_d = v_end ? 10'd0 : v_q + 10'd1;
            end
        end
        hs_d  = !((h_d >= HS_FIRST) && (h_d <= HS_LAST));
        vs_d  = !((v_d >= VS_FIRST) && (v_d <= VS_LAST));
        von_d = (h_d < H_VIS) && (v_d < V_VIS);
    end

    always_ff @(posedge clk) begin
        if (reset_game) begin
            div_q <= 3'd0;
            h_q   <= 10'd0;
            v_q   <= 10'd0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            von_q <= 1'b1;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            von_q <= von_d;
        end
    end

    assign p_tick     = tick_raw & ~reset_game;
    assign frame_tick = p_tick & h_end & v_end;
    assign pixel_x    = h_q;
    assign pixel_y    = v_q;
    assign hsync      = hs_q;
    assign vsync      = vs_q;
    assign video_on   = von_q;

    // Realigns monitor timing with renderers that see pixel data a few clocks late.
    generate
        if (PIPE_DLY == 0) begin : g_no_dly
            assign hsync_d    = hs_q;
            assign vsync_d    = vs_q;
            assign video_on_d = von_q;
        end else begin : g_dly
            logic [PIPE_DLY-1:0] hs_pipe_q, vs_pipe_q, von_pipe_q;

            always_ff @(posedge clk) begin
                if (reset_game) begin
                    hs_pipe_q  <= '1;
                    vs_pipe_q  <= '1;
                    von_pipe_q <= '0;
                end else begin
                    hs_pipe_q[0]  <= hs_q;
                    vs_pipe_q[0]  <= vs_q;
                    von_pipe_q[0] <= von_q;
                    for (int i = 1; i < PIPE_DLY; i++) begin
                        hs_pipe_q[i]  <= hs_pipe_q[i-1];
                        vs_pipe_q[i]  <= vs_pipe_q[i-1];
                        von_pipe_q[i] <= von_pipe_q[i-1];
                    end
                end
            end

            assign hsync_d    = hs_pipe_q[PIPE_DLY-1];
            assign vsync_d    = vs_pipe_q[PIPE_DLY-1];
            assign video_on_d = von_pipe_q[PIPE_DLY-1];
        end
    endgenerate
endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Produces the raster-scan interface consumed by the text overlay, sprite and background renderers.
- Outputs are pixel_x, pixel_y, video_on, hsync and vsync for 640x480 at 60 Hz, derived from the 100 MHz system clock via a pixel-enable divider.
- Provides a per-frame tick for game timing and second_tick generation.
- Provides sync/video_on copies delayed by a parameterised number of clocks, which realign monitor timing with renderers that read the synchronous font ROM (1-clk latency).

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 4, clk cycles per pixel; legal values 1..8
- PIPE_DLY, 1, clk-cycle delay applied to the *_d outputs; legal values 0..4

Ports:
- clk  input  1  system clock, 100 MHz
- reset_game  input  1  synchronous reset, active-high
- p_tick  output  1  one-clk pixel enable; high when the divider is at CLK_DIV-1
- pixel_x  output  10  horizontal counter, 0..H_TOTAL-1 (H_TOTAL = 800)
- pixel_y  output  10  vertical counter, 0..V_TOTAL-1 (V_TOTAL = 525)
- video_on  output  1  high when pixel_x < H_DISPLAY and pixel_y < V_DISPLAY
- hsync  output  1  horizontal sync, active-low
- vsync  output  1  vertical sync, active-low
- frame_tick  output  1  one-clk pulse at end of frame
- hsync_d  output  1  hsync delayed by PIPE_DLY clks
- vsync_d  output  1  vsync delayed by PIPE_DLY clks
- video_on_d  output  1  video_on delayed by PIPE_DLY clks

Behaviour:
- Divider:
  - div_cnt increments every clk and wraps CLK_DIV-1 -> 0.
  - p_tick = (div_cnt == CLK_DIV-1), combinational from the register.
  - CLK_DIV=1: p_tick is constantly 1 out of reset.
- Horizontal counter: h_cnt advances only on p_tick; h_cnt == H_TOTAL-1 on p_tick -> 0.
- Vertical counter:
  - v_cnt advances only on p_tick with h_cnt == H_TOTAL-1.
  - v_cnt == V_TOTAL-1 at that point -> 0.
  - Both counters wrapping together is the frame boundary.
- pixel_x = h_cnt, pixel_y = v_cnt; both are direct register outputs.
- Sync and video decode:
  - hsync, vsync and video_on are registers loaded from the next-state counter values, so they are coincident with pixel_x/pixel_y in every clk.
  - hsync = 0 iff H_DISPLAY+H_FRONT <= h_cnt <= H_DISPLAY+H_FRONT+H_SYNC-1, i.e. 656..751.
  - vsync = 0 iff V_DISPLAY+V_FRONT <= v_cnt <= V_DISPLAY+V_FRONT+V_SYNC-1, i.e. 490..491.
- frame_tick = p_tick & (h_cnt == H_TOTAL-1) & (v_cnt == V_TOTAL-1); exactly one clk per frame.
- Delay lines:
  - *_d outputs are PIPE_DLY-stage shift registers clocked every clk, not gated by p_tick.
  - PIPE_DLY=0 makes each *_d output a combinational pass-through of its source.
- Reset:
  - Any cycle with reset_game=1 loads div_cnt=0, h_cnt=0, v_cnt=0, hsync=1, vsync=1, video_on=1 (decode of (0,0)).
  - All delay stages load hsync_d=1, vsync_d=1, video_on_d=0.
  - p_tick and frame_tick are forced 0 while reset_game=1.
  - Reset mid-frame behaves identically; no partial line or frame state survives.
- First pixel after reset:
  - pixel_x holds 0 for exactly CLK_DIV clks after reset deassertion.
  - It then increments on the clk edge where p_tick was high.

Test Plan:
- Reset release: reset_game high 3 clks then low -> p_tick high on clks 4, 8, 12 after release; pixel_x = 0,1,2 across those intervals; hsync=vsync=1.
- Line wrap: run to pixel_x=799, pixel_y=10 -> after next p_tick, pixel_x=0, pixel_y=11; video_on transitions 0->1 coincident with pixel_x=0.
- Hsync window: over one full line -> hsync low for exactly 96 p_ticks (384 clks), beginning when pixel_x=656 and ending when pixel_x=752; video_on low for pixel_x 640..799.
- Frame and vsync: run two frames -> frame_tick pulses exactly once per 1,680,000 clks; vsync low for pixel_y 490..491 (1600 p_ticks); pixel_y wraps 524->0.
- Delay alignment (PIPE_DLY=1, then 0): compare *_d against sources -> *_d equals the source from the previous clk; with PIPE_DLY=0, *_d equals the source in the same clk; delay regs read 1/1/0 immediately after reset.
- Mid-frame reset at pixel_x=300, pixel_y=200 with div_cnt=2 -> next clk gives pixel_x=0, pixel_y=0, p_tick=0, video_on=1, video_on_d=0; counting resumes per the reset-release scenario.
